chien_sched_p16: RTL

Sequencer for the 16-way parallel Chien search in the BCH decoder, GF(2^13). It takes the error-locator polynomial from the Euclidean stage and loads one coefficient register per locator term. Each cycle it feeds those registers to the external constant-multiplier columns (column j yields reg_j·α^(j·k), k=1..16), sums the returned products per position, and detects roots. It emits one 16-bit root mask per 16-position group under valid/ready handshake and checks the root count against the locator degree.

---
 rtl/bch_pkg.sv | 27 ++
 rtl/chien_root_detect.sv | 42 ++++
 rtl/chien_sched_p16.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// ----------------------------------------------------------------------------
// bch_pkg : shared parameters and types for the GF(2^13) BCH Chien search
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bch_pkg;
  localparam int M      = 13;
  localparam int P      = 16;
  localparam int T      = 8;
  localparam int CW_LEN = 8191;
  localparam int NGRP   = (CW_LEN + P - 1) / P;
  localparam int GRP_W  = $clog2(NGRP);
  localparam int POS_W  = $clog2(NGRP * P + 1);
  localparam int POP_W  = $clog2(P + 1);
  localparam int CNT_W  = 5;

  typedef logic [M-1:0] gf_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/chien_root_detect.sv
// ----------------------------------------------------------------------------
// chien_root_detect : per-position XOR sum, zero detect, tail mask, popcount
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chien_root_detect
  import bch_pkg::*;
(
  input  gf_t                  lambda0,
  input  logic [T*P*M-1:0]     col_prod,
  input  logic [GRP_W-1:0]     grp,
  output logic [P-1:0]         mask,
  output logic [POP_W-1:0]     pop
);

  for (genvar k = 0; k < P; k++) begin : g_pos
    gf_t s;
    localparam logic [POS_W-1:0] OFS = POS_W'(k + 1);

    always_comb begin
      s = lambda0;
      for (int j = 0; j < T; j++) begin
        s = s ^ col_prod[(j*P + k)*M +: M];
      end
    end

    // Positions past the codeword alias onto real roots and must stay silent.
    assign mask[k] = (s == '0) &&
                     ((POS_W'(grp) * POS_W'(P) + OFS) <= POS_W'(CW_LEN));
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < P; k++) begin
      pop = pop + POP_W'(mask[k]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/chien_sched_p16.sv
// ----------------------------------------------------------------------------
// chien_sched_p16 : 16-way parallel Chien search sequencer with root mask output
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chien_sched_p16
  import bch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(T+1)*M-1:0]   lambda_i,
  input  logic [3:0]           lambda_deg,
  output logic [T*M-1:0]       col_reg_o,
  input  logic [T*P*M-1:0]     col_prod_i,
  output logic                 root_valid,
  input  logic                 root_ready,
  output logic [P-1:0]         root_mask,
  output logic [GRP_W-1:0]     root_grp,
  output logic                 busy,
  output logic                 done,
  output logic                 fail
);

  state_t             state_q, state_d;
  logic [T*M-1:0]     coef_q, coef_d;
  gf_t                lambda0_q, lambda0_d;
  logic [3:0]         deg_q, deg_d;
  logic [GRP_W-1:0]   grp_cnt_q, grp_cnt_d;
  logic [CNT_W-1:0]   root_cnt_q, root_cnt_d;
  logic               vld_q, vld_d;
  logic [P-1:0]       mask_q, mask_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;

  logic [P-1:0]       det_mask;
  logic [POP_W-1:0]   det_pop;
  logic [CNT_W:0]     cnt_sum;
  logic               accept;
  logic               advance;

  chien_root_detect u_detect (
    .lambda0  (lambda0_q),
    .col_prod (col_prod_i),
    .grp      (grp_cnt_q),
    .mask     (det_mask),
    .pop      (det_pop)
  );

  assign accept  = vld_q & root_ready;
  assign advance = (state_q == RUN) && (!vld_q || root_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      coef_q     <= '0;
      lambda0_q  <= '0;
      deg_q      <= '0;
      grp_cnt_q  <= '0;
      root_cnt_q <= '0;
      vld_q      <= 1'b0;
      mask_q     <= '0;
      grp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_q     <= coef_d;
      lambda0_q  <= lambda0_d;
      deg_q      <= deg_d;
      grp_cnt_q  <= grp_cnt_d;
      root_cnt_q <= root_cnt_d;
      vld_q      <= vld_d;
      mask_q     <= mask_d;
      grp_q      <= grp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (advance && grp_cnt_q == GRP_W'(NGRP - 1)) state_d = FLUSH;
      FLUSH:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_d     = coef_q;
    lambda0_d  = lambda0_q;
    deg_d      = deg_q;
    grp_cnt_d  = grp_cnt_q;
    root_cnt_d = root_cnt_q;
    vld_d      = vld_q;
    mask_d     = mask_q;
    grp_d      = grp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fail_d     = fail_q;
    cnt_sum    = {1'b0, root_cnt_q} + (CNT_W+1)'(det_pop);

    case (state_q)
      IDLE: begin
        if (start) begin
          coef_d     = lambda_i[(T+1)*M-1:M];
          lambda0_d  = lambda_i[M-1:0];
          deg_d      = lambda_deg;
          grp_cnt_d  = '0;
          root_cnt_d = '0;
          busy_d     = 1'b1;
          fail_d     = 1'b0;
        end
      end
      RUN: begin
        if (advance) begin
          vld_d     = 1'b1;
          mask_d    = det_mask;
          grp_d     = grp_cnt_q;
          grp_cnt_d = grp_cnt_q + 1'b1;
          // Step every register by alpha^(j*P) using the last product of its column.
          for (int j = 0; j < T; j++) begin
            coef_d[j*M +: M] = col_prod_i[(j*P + P - 1)*M +: M];
          end
          root_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
      end
      FLUSH: begin
        if (accept) begin
          vld_d  = 1'b0;
          done_d = 1'b1;
          busy_d = 1'b0;
          fail_d = (CNT_W'(deg_q) != root_cnt_q);
        end
      end
      default: ;
    endcase
  end

  assign col_reg_o  = coef_q;
  assign root_valid = vld_q;
  assign root_mask  = mask_q;
  assign root_grp   = grp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule

`default_nettype wire
